// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame sequencer.
//   seq_state_t          sequencer FSM state encoding (2-bit)
//   HEADER_BYTE_DEFAULT  default first byte of every frame
//   frame_len()          header + data bytes + checksum
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } seq_state_t;

    localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

    function automatic int frame_len(input int word_bytes);
        return word_bytes + 2;
    endfunction

endpackage

// File: rtl/uart_frame_sequencer_if.sv
// Handshake bundle between the word source, the sequencer and the UART TX.
//   in_valid/in_data/in_ready   valid/ready word input
//   tx_start/tx_data/tx_busy    byte interface to the UART transmitter
//   frame_busy/frames_sent/ack_err   status
// Modports: master = the sequencer, slave = its environment (source, TX, status reader).
interface uart_frame_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              frame_busy;
    logic [15:0]       frames_sent;
    logic              ack_err;

    modport master (
        input  in_valid, in_data, tx_busy,
        output in_ready, tx_start, tx_data, frame_busy, frames_sent, ack_err
    );

    modport slave (
        output in_valid, in_data, tx_busy,
        input  in_ready, tx_start, tx_data, frame_busy, frames_sent, ack_err
    );
endinterface

// File: rtl/uart_frame_sequencer.sv
// Sequences a shared byte-wide UART transmitter. Each accepted word is sent as
// one frame: HEADER_BYTE, data bytes MSB first, XOR checksum of all previous bytes.
// Ports:
//   clk   system clock, posedge
//   rst   asynchronous active-high reset; aborts any frame in flight
//   bus   uart_frame_sequencer_if.master (word input, TX byte interface, status)
// One word can wait in a hold buffer while a frame is on the wire. Each byte is
// handed to the TX with a one-cycle tx_start pulse; if tx_busy does not rise
// within ACK_TIMEOUT cycles the pulse is repeated and ack_err is latched.
module uart_frame_sequencer
    import uart_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT,
    parameter int         WORD_BYTES  = 4,
    parameter int         ACK_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_frame_sequencer_if.master bus
);

    localparam int DATA_W    = 8 * WORD_BYTES;
    localparam int FRAME_LEN = frame_len(WORD_BYTES);
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int CNT_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    seq_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_next;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              frame_busy_q, frame_busy_d;
    logic [15:0]       frames_sent_q, frames_sent_d;
    logic              ack_err_q, ack_err_d;

    logic              hold_valid_q;
    logic [DATA_W-1:0] hold_data_q;
    logic              accept;
    logic              load;

    logic [7:0]        frame_q [FRAME_LEN];
    logic [7:0]        frame_d [FRAME_LEN];

    // in_ready is low whenever the buffer is full, so accept and load never coincide.
    assign accept   = bus.in_valid && !hold_valid_q;
    assign idx_next = idx_q + 1'b1;

    // Frame image built straight from the hold buffer, captured on load.
    always_comb begin
        logic [7:0] sum;
        sum        = HEADER_BYTE;
        frame_d[0] = HEADER_BYTE;
        for (int i = 0; i < WORD_BYTES; i++) begin
            frame_d[i+1] = hold_data_q[DATA_W-1-8*i -: 8];
            sum          = sum ^ hold_data_q[DATA_W-1-8*i -: 8];
        end
        frame_d[FRAME_LEN-1] = sum;
    end

    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        frame_busy_d  = frame_busy_q;
        frames_sent_d = frames_sent_q;
        ack_err_d     = ack_err_q;
        load          = 1'b0;

        case (state_q)
            IDLE: begin
                // A TX left shifting by a mid-frame reset must drain before we start.
                if (hold_valid_q && !bus.tx_busy) begin
                    load         = 1'b1;
                    idx_d        = '0;
                    tx_data_d    = HEADER_BYTE;
                    tx_start_d   = 1'b1;
                    frame_busy_d = 1'b1;
                    state_d      = SEND;
                end
            end
            SEND: begin
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // tx_busy is tested first so it wins over a coincident timeout.
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    ack_err_d  = 1'b1;
                    tx_start_d = 1'b1;
                    state_d    = SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        frame_busy_d  = 1'b0;
                        frames_sent_d = frames_sent_q + 16'd1;
                        state_d       = IDLE;
                    end else begin
                        idx_d      = idx_next;
                        tx_data_d  = frame_q[idx_next];
                        tx_start_d = 1'b1;
                        state_d    = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            frame_busy_q  <= 1'b0;
            frames_sent_q <= 16'h0000;
            ack_err_q     <= 1'b0;
            hold_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            frame_busy_q  <= frame_busy_d;
            frames_sent_q <= frames_sent_d;
            ack_err_q     <= ack_err_d;
            if (accept) begin
                hold_valid_q <= 1'b1;
            end else if (load) begin
                hold_valid_q <= 1'b0;
            end
        end
    end

    // NOTE: data storage is deliberately not reset; its contents only matter
    // while hold_valid_q / the FSM says they are valid, and skipping the reset
    // keeps these as plain enable flops.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_data_q <= bus.in_data;
        end
        if (load) begin
            frame_q <= frame_d;
        end
    end

    assign bus.in_ready    = ~hold_valid_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.frame_busy  = frame_busy_q;
    assign bus.frames_sent = frames_sent_q;
    assign bus.ack_err     = ack_err_q;

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Bench for uart_frame_sequencer: drives it into a behavioural UART TX
// (BIT_PERIOD = 4 clocks, no reset), decodes the serial line and compares every
// decoded byte against a queue of expected bytes pushed when each word is sent.
// A stub mode holds tx_busy low to exercise the acknowledge timeout.
module tb_uart_frame_sequencer;

    localparam int WORD_BYTES  = 4;
    localparam int DATA_W      = 8 * WORD_BYTES;
    localparam int ACK_TIMEOUT = 8;
    localparam int BIT_PERIOD  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    uart_frame_sequencer_if #(.DATA_W(DATA_W)) bus ();

    uart_frame_sequencer #(
        .HEADER_BYTE (8'hA5),
        .WORD_BYTES  (WORD_BYTES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- behavioural UART TX (no reset) ----------------
    logic       stub_mode = 1'b0;
    logic       uart_busy = 1'b0;
    logic       txd       = 1'b1;
    logic [9:0] shreg     = 10'h3FF;
    int         bit_n     = 0;
    int         tick      = 0;

    assign bus.tx_busy = stub_mode ? 1'b0 : uart_busy;

    always @(posedge clk) begin
        if (!uart_busy) begin
            if (bus.tx_start && !stub_mode) begin
                uart_busy <= 1'b1;
                shreg     <= {1'b1, bus.tx_data, 1'b0};
                bit_n     <= 0;
                tick      <= 0;
                txd       <= 1'b0;
            end
        end else if (tick == BIT_PERIOD - 1) begin
            tick <= 0;
            if (bit_n == 9) begin
                uart_busy <= 1'b0;
                txd       <= 1'b1;
            end else begin
                bit_n <= bit_n + 1;
                txd   <= shreg[bit_n+1];
            end
        end else begin
            tick <= tick + 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q [$];
    logic       sb_mute = 1'b0;

    task automatic push_word(input logic [DATA_W-1:0] w);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'hA5;
        exp_q.push_back(8'hA5);
        for (int i = WORD_BYTES - 1; i >= 0; i--) begin
            b = w[8*i +: 8];
            exp_q.push_back(b);
            x = x ^ b;
        end
        exp_q.push_back(x);
    endtask

    // Serial decoder: samples mid-bit, compares each byte against the queue head.
    always begin
        logic [7:0] b;
        logic [7:0] e;
        logic       stop_b;
        @(negedge txd);
        repeat (BIT_PERIOD / 2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (BIT_PERIOD) @(posedge clk);
            #1 b[i] = txd;
        end
        repeat (BIT_PERIOD) @(posedge clk);
        #1 stop_b = txd;
        if (!sb_mute) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL serial_byte: got %h, expected no byte", b);
            end else begin
                e = exp_q.pop_front();
                if (b !== e || stop_b !== 1'b1) begin
                    errors++;
                    $display("FAIL serial_byte: got %h stop=%b, expected %h stop=1", b, stop_b, e);
                end
            end
        end
    end

    // ---------------- tx_start width / tx_data stability monitor ----------------
    logic       mon_on     = 1'b0;
    logic       start_prev = 1'b0;
    logic       holding    = 1'b0;
    logic       data_bad   = 1'b0;
    logic       busy_prev  = 1'b0;
    logic [7:0] held       = 8'h00;

    always @(negedge clk) begin
        if (!mon_on || rst) begin
            start_prev = 1'b0;
            holding    = 1'b0;
            busy_prev  = 1'b0;
        end else begin
            if (start_prev) begin
                checks++;
                if (bus.tx_start !== 1'b0) begin
                    errors++;
                    $display("FAIL tx_start_width: got %b one cycle after pulse, expected 0", bus.tx_start);
                end
            end
            start_prev = bus.tx_start;
            if (bus.tx_start) begin
                held     = bus.tx_data;
                holding  = 1'b1;
                data_bad = 1'b0;
            end else if (holding) begin
                if (bus.tx_data !== held) data_bad = 1'b1;
                if (busy_prev && !bus.tx_busy) begin
                    checks++;
                    holding = 1'b0;
                    if (data_bad) begin
                        errors++;
                        $display("FAIL tx_data_stable: got %h at end, expected %h held", bus.tx_data, held);
                    end
                end
            end
            busy_prev = bus.tx_busy;
        end
    end

    // ---------------- helpers ----------------
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one word and wait (bounded) for its accept edge.
    task automatic send_word(input logic [DATA_W-1:0] w, input logic expect_bytes);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        while (!bus.in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready never rose, expected accept of %h", w);
        end
        if (expect_bytes) push_word(w);
        @(posedge clk);
    endtask

    task automatic wait_frames(input logic [15:0] target);
        int n;
        n = 0;
        while (bus.frames_sent !== target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL frames_sent_wait: got %h, expected %h", bus.frames_sent, target);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        checks += 6;
        if (bus.tx_start !== 1'b0)       begin errors++; $display("FAIL reset_tx_start: got %b, expected 0", bus.tx_start); end
        if (bus.tx_data !== 8'h00)       begin errors++; $display("FAIL reset_tx_data: got %h, expected 00", bus.tx_data); end
        if (bus.frame_busy !== 1'b0)     begin errors++; $display("FAIL reset_frame_busy: got %b, expected 0", bus.frame_busy); end
        if (bus.frames_sent !== 16'h0)   begin errors++; $display("FAIL reset_frames_sent: got %h, expected 0000", bus.frames_sent); end
        if (bus.ack_err !== 1'b0)        begin errors++; $display("FAIL reset_ack_err: got %b, expected 0", bus.ack_err); end
        if (bus.in_ready !== 1'b1)       begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        reset_dut();
        mon_on = 1'b1;
        send_word(32'h3F800000, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks += 2;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL latency_hold: in_ready got %b, expected 0", bus.in_ready); end
        if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL latency_early: tx_start got %b, expected 0", bus.tx_start); end
        @(negedge clk);
        checks += 3;
        if (bus.tx_start !== 1'b1)   begin errors++; $display("FAIL latency_start: tx_start got %b, expected 1", bus.tx_start); end
        if (bus.tx_data !== 8'hA5)   begin errors++; $display("FAIL latency_header: tx_data got %h, expected a5", bus.tx_data); end
        if (bus.frame_busy !== 1'b1) begin errors++; $display("FAIL latency_busy: frame_busy got %b, expected 1", bus.frame_busy); end
        wait_frames(16'd1);
        checks += 4;
        if (bus.frame_busy !== 1'b0) begin errors++; $display("FAIL single_frame_busy: got %b, expected 0", bus.frame_busy); end
        if (bus.tx_busy !== 1'b0)    begin errors++; $display("FAIL single_tx_idle: tx_busy got %b, expected 0", bus.tx_busy); end
        if (bus.ack_err !== 1'b0)    begin errors++; $display("FAIL single_ack_err: got %b, expected 0", bus.ack_err); end
        if (exp_q.size() != 0)       begin errors++; $display("FAIL single_bytes_left: got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        send_word(32'h3F800000, 1'b1);
        send_word(32'hDEADBEEF, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks += 3;
        if (bus.frame_busy !== 1'b1)   begin errors++; $display("FAIL b2b_inflight: frame_busy got %b, expected 1", bus.frame_busy); end
        if (bus.frames_sent !== 16'd0) begin errors++; $display("FAIL b2b_inflight_count: got %h, expected 0000", bus.frames_sent); end
        if (bus.in_ready !== 1'b0)     begin errors++; $display("FAIL b2b_full: in_ready got %b, expected 0", bus.in_ready); end
        wait_frames(16'd1);
        checks += 3;
        if (bus.in_ready !== 1'b0)   begin errors++; $display("FAIL b2b_gap_ready: got %b, expected 0", bus.in_ready); end
        if (bus.frame_busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy: got %b, expected 0", bus.frame_busy); end
        if (bus.tx_start !== 1'b0)   begin errors++; $display("FAIL b2b_gap_start: got %b, expected 0", bus.tx_start); end
        @(negedge clk);
        checks += 4;
        if (bus.tx_start !== 1'b1)   begin errors++; $display("FAIL b2b_restart: tx_start got %b, expected 1", bus.tx_start); end
        if (bus.tx_data !== 8'hA5)   begin errors++; $display("FAIL b2b_header: tx_data got %h, expected a5", bus.tx_data); end
        if (bus.frame_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy2: got %b, expected 1", bus.frame_busy); end
        if (bus.in_ready !== 1'b1)   begin errors++; $display("FAIL b2b_ready2: got %b, expected 1", bus.in_ready); end
        wait_frames(16'd2);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_bytes_left: got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_ack_timeout();
        int n;
        reset_dut();
        stub_mode = 1'b1;
        send_word(32'h3F800000, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.tx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks += 2;
        if (bus.tx_start !== 1'b1) begin errors++; $display("FAIL timeout_first_pulse: got %b, expected 1", bus.tx_start); end
        if (bus.ack_err !== 1'b0)  begin errors++; $display("FAIL timeout_err_early: got %b, expected 0", bus.ack_err); end
        for (int p = 0; p < 3; p++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.tx_start && n < 50);
            checks += 3;
            if (n != ACK_TIMEOUT + 1)  begin errors++; $display("FAIL timeout_period: got %0d cycles, expected %0d", n, ACK_TIMEOUT + 1); end
            if (bus.tx_data !== 8'hA5) begin errors++; $display("FAIL timeout_data: got %h, expected a5", bus.tx_data); end
            if (bus.ack_err !== 1'b1)  begin errors++; $display("FAIL timeout_err: got %b, expected 1", bus.ack_err); end
        end
        checks += 2;
        if (bus.frame_busy !== 1'b1)   begin errors++; $display("FAIL timeout_busy: got %b, expected 1", bus.frame_busy); end
        if (bus.frames_sent !== 16'd0) begin errors++; $display("FAIL timeout_count: got %h, expected 0000", bus.frames_sent); end
        reset_dut();
        stub_mode = 1'b0;
        checks++;
        if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL timeout_err_cleared: got %b, expected 0", bus.ack_err); end
    endtask

    task automatic test_mid_frame_reset();
        int  n;
        int  pulses;
        logic early;
        reset_dut();
        send_word(32'h12345678, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        pulses = 0;
        n = 0;
        while (pulses < 3 && n < 1000) begin
            @(negedge clk);
            n++;
            if (bus.tx_start) pulses++;
        end
        while (!bus.tx_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL reset_setup: third byte not seen, expected it within 1000 cycles");
        end
        repeat (8) @(negedge clk);
        sb_mute = 1'b1;
        mon_on  = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks += 6;
        if (bus.tx_start !== 1'b0)     begin errors++; $display("FAIL async_tx_start: got %b, expected 0", bus.tx_start); end
        if (bus.tx_data !== 8'h00)     begin errors++; $display("FAIL async_tx_data: got %h, expected 00", bus.tx_data); end
        if (bus.frame_busy !== 1'b0)   begin errors++; $display("FAIL async_frame_busy: got %b, expected 0", bus.frame_busy); end
        if (bus.frames_sent !== 16'd0) begin errors++; $display("FAIL async_frames_sent: got %h, expected 0000", bus.frames_sent); end
        if (bus.in_ready !== 1'b1)     begin errors++; $display("FAIL async_in_ready: got %b, expected 1", bus.in_ready); end
        if (bus.tx_busy !== 1'b1)      begin errors++; $display("FAIL async_tx_still_busy: got %b, expected 1", bus.tx_busy); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        send_word(32'h40490FDB, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        early = 1'b0;
        n = 0;
        while (bus.tx_busy && n < 200) begin
            if (bus.tx_start) early = 1'b1;
            @(negedge clk);
            n++;
        end
        checks++;
        if (early || n >= 200) begin
            errors++;
            $display("FAIL start_while_busy: got early=%b wait=%0d, expected no tx_start before tx_busy falls", early, n);
        end
        sb_mute = 1'b0;
        mon_on  = 1'b1;
        wait_frames(16'd1);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL reset_bytes_left: got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_count_wrap();
        reset_dut();
        @(negedge clk);
        force dut.frames_sent_q = 16'hFFFF;
        @(negedge clk);
        release dut.frames_sent_q;
        @(negedge clk);
        checks++;
        if (bus.frames_sent !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h, expected ffff", bus.frames_sent); end
        send_word(32'hC0000001, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_frames(16'h0000);
        checks += 2;
        if (bus.frame_busy !== 1'b0) begin errors++; $display("FAIL wrap_busy: got %b, expected 0", bus.frame_busy); end
        if (exp_q.size() != 0)       begin errors++; $display("FAIL wrap_bytes_left: got %0d, expected 0", exp_q.size()); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ack_timeout();
        test_mid_frame_reset();
        test_count_wrap();
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 50000 cycles, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
